// File: rtl/field_decoder_if.sv
// field_decoder_if
//   Handshake bundle between a code producer and the field decoder.
//   Input side : in_valid / in_ready / code_in   (64-bit receptive-field code)
//   Output side: out_valid / out_ready / img / err_flag / err_cnt
//   Modports:
//     master - the side that supplies codes and consumes decoded images
//     slave  - the decoder itself
interface field_decoder_if #(
    parameter int ERR_CNT_W = 6
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [63:0]          code_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [24:0]          img;
    logic                 err_flag;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid,
        input  in_ready,
        output code_in,
        input  out_valid,
        output out_ready,
        input  img,
        input  err_flag,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  code_in,
        output out_valid,
        input  out_ready,
        output img,
        output err_flag,
        output err_cnt
    );
endinterface

// File: rtl/field_decoder.sv
// field_decoder
//   Rebuilds a 5x5 binary image from sixteen overlapping 2x2 fields (4x4 grid,
//   stride 1), one field per clock, and counts pixels on which overlapping
//   fields disagree. The first value written to a pixel wins.
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low reset
//     clear  - synchronous flush back to IDLE, dominates every other input
//     bus    - field_decoder_if.slave (code in, image/error result out)
//
//   state  | meaning
//   IDLE   | in_ready high, waiting for a code
//   DECODE | applying field k to the image, k = 0..15
//   DONE   | out_valid high, result held until out_ready
module field_decoder #(
    parameter int CHECK_EN  = 1,
    parameter int ERR_CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    field_decoder_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    logic [3:0]           k;
    logic [63:0]          code_r;
    logic [24:0]          img_r;
    logic [24:0]          wmask;
    logic                 err_flag_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic                 in_ready_r;
    logic                 out_valid_r;

    logic [63:0] code_sh;
    logic [3:0]  fld;
    logic [24:0] img_nx;
    logic [24:0] wmask_nx;
    logic [2:0]  conf_nx;
    logic [4:0]  pix;

    // Field k sits at code_r[63-4k -: 4]; shifting left by 4k brings it to the top nibble.
    // Nibble bit 3-n covers pixel (i + n/2, j + n%2), where i = k[3:2], j = k[1:0].
    always_comb begin
        img_nx   = img_r;
        wmask_nx = wmask;
        conf_nx  = '0;
        pix      = '0;
        code_sh  = code_r << {k, 2'b00};
        fld      = code_sh[63:60];
        for (int n = 0; n < 4; n++) begin
            pix = 5'(24 - 5 * (int'(k[3:2]) + n / 2) - (int'(k[1:0]) + n % 2));
            if (!wmask_nx[pix]) begin
                img_nx[pix]   = fld[2'(3 - n)];
                wmask_nx[pix] = 1'b1;
            end else if (img_nx[pix] != fld[2'(3 - n)]) begin
                conf_nx = conf_nx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            code_r      <= '0;
            img_r       <= '0;
            wmask       <= '0;
            err_flag_r  <= 1'b0;
            err_cnt_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            k           <= '0;
            img_r       <= '0;
            wmask       <= '0;
            err_flag_r  <= 1'b0;
            err_cnt_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        code_r     <= bus.code_in;
                        img_r      <= '0;
                        wmask      <= '0;
                        err_flag_r <= 1'b0;
                        err_cnt_r  <= '0;
                        k          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    img_r <= img_nx;
                    wmask <= wmask_nx;
                    if (CHECK_EN != 0 && conf_nx != 3'd0) begin
                        // At most 39 conflicts per image, so no saturation is needed.
                        err_cnt_r  <= err_cnt_r + ERR_CNT_W'(conf_nx);
                        err_flag_r <= 1'b1;
                    end
                    if (k == 4'd15) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.img       = img_r;
    assign bus.err_flag  = err_flag_r;
    assign bus.err_cnt   = err_cnt_r;

endmodule
